ram_frame_loader: RTL
=====================

Name: ram_frame_loader

Overview:
- Upstream feeder for the parallel register bank (Ram).
- Accepts BIT_SIZE-bit words serially over a valid/ready handshake and packs RAM_SIZE of them into one flattened frame.
- Presents the frame on par_out and holds ld high until the downstream stage acknowledges the load.
- par_out and ld connect directly to the bank's par_in and ld.

Parameters:
BIT_SIZE, 16, width of one word.
RAM_SIZE, 8, words per frame (>=2).
CNT_W, $clog2(RAM_SIZE+1), width of fill_cnt (localparam, derived).

Ports:
clk  in  1  clock; all state updates on posedge clk.
rst  in  1  reset; asynchronous, active-low.
clear  in  1  synchronous; discards the partial frame being filled.
in_valid  in  1  in_data holds a valid word.
in_data  in  BIT_SIZE  serial input word.
in_ready  out  1  loader can accept a word this cycle.
load_ready  in  1  downstream takes the frame this cycle.
ld  out  1  frame valid; drives the bank's ld.
par_out  out  RAM_SIZE*BIT_SIZE  assembled frame; word k occupies bits [k*BIT_SIZE +: BIT_SIZE].
fill_cnt  out  CNT_W  words accepted into the current partial frame.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst).
- Reset values: state=FILL, write index 0, fill_cnt 0, par_out all zeros, ld 0, in_ready 1 once rst deasserts.
- Transfer rule: a word transfers on a rising edge when in_valid & in_ready.
- Load rule: a load completes on a rising edge when ld & load_ready.

FILL state:
- in_ready = ~clear; ld = 0.
- On transfer: in_data is written to slot idx, idx increments, fill_cnt increments.
- When the transfer hits idx == RAM_SIZE-1: idx wraps to 0, fill_cnt returns to 0, and the state goes to LOAD.
- Net effect: ld rises in the cycle after the last word's edge (1-cycle latency).

LOAD state:
- ld = 1; in_ready = 0; par_out is stable and equals the complete frame.
- Stays in LOAD until load_ready = 1, then returns to FILL on that edge.
- ld lasts at least one cycle.
- load_ready is ignored whenever ld = 0.

par_out update rules:
- Only the slot being written changes during FILL.
- Unwritten slots keep their previous-frame contents. There is no zeroing between frames.

clear:
- In FILL: idx and fill_cnt go to 0 and the partial frame is discarded.
- clear has priority over a simultaneous in_valid, because in_ready is forced to 0 that cycle.
- In LOAD: clear has no effect. A frame that is already presented is never aborted.

Back-to-back frames:
- Without the optional feature there is exactly one FILL-entry bubble: the first word of the next frame can be accepted in the cycle after the load handshake.

Reset mid-operation:
- Reset asserted in any state returns immediately to the reset values.
- A pending frame is lost and ld drops asynchronously.

in_valid behaviour:
- in_valid may stay high while in_ready is low. The word is held by the source, not dropped.

Optional Feature:
Macro RAM_FRAME_LOADER_DBUF_EN.
- Defined: two frame banks (double buffering).
  - While LOAD presents bank A, in_ready stays 1 (unless clear is high) and incoming words fill bank B. fill_cnt tracks bank B.
  - If bank B completes before the handshake, in_ready drops to 0 until the handshake.
  - On the handshake, if bank B is full, the loader stays in LOAD and presents B on the next cycle. ld remains high and par_out switches to B.
  - Otherwise the loader enters FILL and continues filling B.
  - clear during LOAD discards only the partial contents of bank B.
- Undefined: single bank; behaviour exactly as above.

Test Plan:
1. Reset, then stream 0x0001..0x0008 with in_valid held high and load_ready=0 -> ld rises one cycle after the 8th transfer; par_out = {0x0008,...,0x0001} with 0x0001 in bits[15:0]; in_ready=0; ld stays high for 5 cycles; load_ready=1 -> ld=0 next cycle, fill_cnt=0.
2. Feed 3 words, then pulse clear together with in_valid=1 (data 0xBEEF) -> in_ready=0 that cycle, fill_cnt=0 after the edge; the next 8 words form the frame; 0xBEEF never appears.
3. load_ready held at 1 and in_valid toggled every other cycle -> frames complete every 16+1 cycles; ld pulses exactly 1 cycle per frame; contents match the sequence.
4. Assert rst low mid-frame (fill_cnt=5) asynchronously between edges -> par_out=0, ld=0, fill_cnt=0 immediately; the next full frame loads correctly.
5. In LOAD, assert clear with load_ready=0 -> ld stays 1 and par_out is unchanged.
6. (DBUF_EN) Hold load_ready=0 while 16 words stream in -> first frame presented, second fills, then in_ready=0; pulse load_ready -> ld stays 1 and par_out becomes the second frame on the next cycle.

Source files
------------

// File: rtl/ram_frame_loader.sv
// Serial-to-parallel frame loader feeding the parallel register bank.
// Define RAM_FRAME_LOADER_DBUF_EN for a second fill bank (double buffering).
module ram_frame_loader #(
  parameter  int BIT_SIZE = 16,
  parameter  int RAM_SIZE = 8,
  localparam int CNT_W    = $clog2(RAM_SIZE + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic [BIT_SIZE-1:0]          in_data,
  output logic                         in_ready,
  input  logic                         load_ready,
  output logic                         ld,
  output logic [RAM_SIZE*BIT_SIZE-1:0] par_out,
  output logic [CNT_W-1:0]             fill_cnt
);

  localparam int IDX_W = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
  localparam int W     = RAM_SIZE * BIT_SIZE;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(RAM_SIZE - 1);

  typedef enum logic {FILL, LOAD} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;

`ifdef RAM_FRAME_LOADER_DBUF_EN

  // par_out is the presented bank; fill_buf is the bank being filled.
  logic [W-1:0] fill_buf;
  logic [W-1:0] wr_frame;
  logic         b_full;
  logic         accept;
  logic         last;

  assign in_ready = ~clear & ~b_full;
  assign accept   = in_valid & in_ready;
  assign last     = accept & (idx == LAST);

  always_comb begin
    wr_frame = fill_buf;
    for (int unsigned k = 0; k < RAM_SIZE; k++) begin
      if (accept && (IDX_W'(k) == idx)) begin
        wr_frame[k*BIT_SIZE +: BIT_SIZE] = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FILL;
      idx      <= '0;
      fill_cnt <= '0;
      par_out  <= '0;
      fill_buf <= '0;
      b_full   <= 1'b0;
      ld       <= 1'b0;
    end else begin
      if (clear) begin
        idx      <= '0;
        fill_cnt <= '0;
      end else if (accept) begin
        fill_buf <= wr_frame;
        if (last) begin
          idx      <= '0;
          fill_cnt <= '0;
        end else begin
          idx      <= idx + IDX_W'(1);
          fill_cnt <= fill_cnt + CNT_W'(1);
        end
      end

      case (state)
        FILL: begin
          if (last) begin
            par_out <= wr_frame;
            state   <= LOAD;
            ld      <= 1'b1;
          end
        end
        LOAD: begin
          // A bank completing on the handshake edge is presented directly.
          if (load_ready) begin
            if (b_full) begin
              par_out <= fill_buf;
              b_full  <= 1'b0;
            end else if (last) begin
              par_out <= wr_frame;
            end else begin
              state <= FILL;
              ld    <= 1'b0;
            end
          end else if (last) begin
            b_full <= 1'b1;
          end
        end
        default: begin
          state <= FILL;
          ld    <= 1'b0;
        end
      endcase
    end
  end

`else

  assign in_ready = (state == FILL) & ~clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FILL;
      idx      <= '0;
      fill_cnt <= '0;
      par_out  <= '0;
      ld       <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (clear) begin
            idx      <= '0;
            fill_cnt <= '0;
          end else if (in_valid) begin
            for (int unsigned k = 0; k < RAM_SIZE; k++) begin
              if (IDX_W'(k) == idx) begin
                par_out[k*BIT_SIZE +: BIT_SIZE] <= in_data;
              end
            end
            if (idx == LAST) begin
              idx      <= '0;
              fill_cnt <= '0;
              state    <= LOAD;
              ld       <= 1'b1;
            end else begin
              idx      <= idx + IDX_W'(1);
              fill_cnt <= fill_cnt + CNT_W'(1);
            end
          end
        end
        LOAD: begin
          if (load_ready) begin
            state <= FILL;
            ld    <= 1'b0;
          end
        end
        default: begin
          state <= FILL;
          ld    <= 1'b0;
        end
      endcase
    end
  end

`endif

endmodule
